// File: rtl/issue_hazard_sched.sv
// Dual-issue hazard scheduler: late-result interlocks over E/M1/M2 plus HI/LO busy tracking.
// Optional HAZARD_PERF_CNT_EN adds stall / single-issue cycle counters as extra output ports.
module issue_hazard_sched #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      in_valid,
    input  logic [1:0][4:0] in_ra1,
    input  logic [1:0][4:0] in_ra2,
    input  logic [1:0][4:0] in_rdst,
    input  logic [1:0]      in_regwrite,
    input  logic [1:0]      in_late,
    input  logic [1:0][1:0] in_md_op,
    input  logic [1:0]      in_hilo_rd,
    input  logic            pipe_stall,
    input  logic            flush,
    output logic [1:0]      issue_en,
    output logic            issue_stall,
    output logic            md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cyc,
    output logic [31:0]     perf_single_cyc
`endif
);

    typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;

    // Index 0 = E, 1 = M1, 2 = M2. A producer in M3 is forwardable, so its entry is not retained.
    logic [2:0][1:0]      vld_q, vld_d;
    logic [2:0][1:0]      late_q, late_d;
    logic [2:0][1:0][4:0] rdst_q, rdst_d;
    logic [3:0]           md_cnt_q, md_cnt_d;
    md_state_t            md_state_q, md_state_d;

    logic [1:0] issue_en_s;
    logic [1:0] hazard_s;
    logic [1:0] hilo_ok_s;
    logic       pair_dep_s;
    logic       md_load_s;
    logic [1:0] md_op_s;

    function automatic logic late_hazard(input logic [4:0] r,
                                         input logic [2:0][1:0] vld,
                                         input logic [2:0][1:0] late,
                                         input logic [2:0][1:0][4:0] rdst);
        logic hit;
        hit = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int l = 0; l < 2; l++) begin
                hit = hit | (vld[s][l] & late[s][l] & (rdst[s][l] == r));
            end
        end
        return hit & (r != 5'd0);
    endfunction

    // Issue decision for both slots, HI/LO counter and tracking next-state.
    always_comb begin
        issue_en_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            hazard_s[i]  = late_hazard(in_ra1[i], vld_q, late_q, rdst_q) |
                           late_hazard(in_ra2[i], vld_q, late_q, rdst_q);
            hilo_ok_s[i] = ((in_hilo_rd[i] == 1'b0) && (in_md_op[i] == 2'b00)) || (md_cnt_q == 4'd0);
        end
        pair_dep_s = (in_regwrite[0] && (in_rdst[0] != 5'd0) &&
                      ((in_rdst[0] == in_ra1[1]) || (in_rdst[0] == in_ra2[1]))) ||
                     ((in_md_op[0] != 2'b00) && (in_hilo_rd[1] || (in_md_op[1] != 2'b00))) ||
                     (in_late[0] && in_late[1]);
        issue_en_s[0] = in_valid[0] & ~pipe_stall & ~flush & ~reset & ~hazard_s[0] & hilo_ok_s[0];
        issue_en_s[1] = issue_en_s[0] & in_valid[1] & ~hazard_s[1] & hilo_ok_s[1] & ~pair_dep_s;

        if (issue_en_s[0] && (in_md_op[0] != 2'b00)) begin
            md_op_s = in_md_op[0];
        end else if (issue_en_s[1] && (in_md_op[1] != 2'b00)) begin
            md_op_s = in_md_op[1];
        end else begin
            md_op_s = 2'b00;
        end
        md_load_s = (md_op_s != 2'b00);

        case (md_op_s)
            2'b01:   md_cnt_d = 4'(MUL_LAT);
            2'b10:   md_cnt_d = 4'(DIV_LAT);
            2'b11:   md_cnt_d = 4'd1;
            default: md_cnt_d = (md_cnt_q != 4'd0) ? (md_cnt_q - 4'd1) : md_cnt_q;
        endcase

        case (md_state_q)
            MD_IDLE: md_state_d = md_load_s ? MD_BUSY : MD_IDLE;
            MD_BUSY: md_state_d = (md_cnt_d == 4'd0) ? MD_IDLE : MD_BUSY;
            default: md_state_d = MD_IDLE;
        endcase

        // A flushed E entry is killed, not shifted into M1.
        if (!pipe_stall) begin
            vld_d[2]  = vld_q[1];
            late_d[2] = late_q[1];
            rdst_d[2] = rdst_q[1];
            vld_d[1]  = vld_q[0] & {2{~flush}};
            late_d[1] = late_q[0];
            rdst_d[1] = rdst_q[0];
            vld_d[0]  = issue_en_s;
            late_d[0] = in_late & in_regwrite;
            rdst_d[0] = in_rdst;
        end else begin
            vld_d     = vld_q;
            late_d    = late_q;
            rdst_d    = rdst_q;
            vld_d[0]  = flush ? 2'b00 : vld_q[0];
        end
    end

    // Tracking pipeline, HI/LO counter and md FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q      <= '0;
            late_q     <= '0;
            rdst_q     <= '0;
            md_cnt_q   <= 4'd0;
            md_state_q <= MD_IDLE;
        end else begin
            vld_q      <= vld_d;
            late_q     <= late_d;
            rdst_q     <= rdst_d;
            md_cnt_q   <= md_cnt_d;
            md_state_q <= md_state_d;
        end
    end

    assign issue_en    = issue_en_s;
    assign issue_stall = in_valid[0] & ~issue_en_s[0] & ~pipe_stall & ~flush & ~reset;
    assign md_busy     = (md_state_q == MD_BUSY) & ~reset;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;
    logic [31:0] perf_single_cyc_q, perf_single_cyc_d;

    // Performance counter increments; both wrap naturally at 2^32.
    always_comb begin
        perf_stall_cyc_d  = perf_stall_cyc_q + {31'd0, issue_stall};
        perf_single_cyc_d = perf_single_cyc_q +
                            {31'd0, ((issue_en_s == 2'b01) && (in_valid == 2'b11))};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cyc_q  <= 32'd0;
            perf_single_cyc_q <= 32'd0;
        end else begin
            perf_stall_cyc_q  <= perf_stall_cyc_d;
            perf_single_cyc_q <= perf_single_cyc_d;
        end
    end

    assign perf_stall_cyc  = perf_stall_cyc_q;
    assign perf_single_cyc = perf_single_cyc_q;
`endif

endmodule

// File: tb/tb_issue_hazard_sched.sv
// Randomized instruction-stream bench for issue_hazard_sched with a scoreboard and an age-based
// reference model (list of late producers with pipeline age, HI/LO free-at cycle number).
module tb_issue_hazard_sched;

    localparam int MUL_LAT_TB = 3;
    localparam int DIV_LAT_TB = 12;
    localparam int NCYC       = 3000;
    localparam int QUIET      = 40;

    typedef struct packed {
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [4:0] rdst;
        logic       rw;
        logic       late;
        logic [1:0] md;
        logic       hr;
    } instr_t;

    typedef struct {
        logic [4:0] rdst;
        int         age;
    } prod_t;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [1:0]      in_valid;
    logic [1:0][4:0] in_ra1;
    logic [1:0][4:0] in_ra2;
    logic [1:0][4:0] in_rdst;
    logic [1:0]      in_regwrite;
    logic [1:0]      in_late;
    logic [1:0][1:0] in_md_op;
    logic [1:0]      in_hilo_rd;
    logic            pipe_stall;
    logic            flush;
    logic [1:0]      issue_en;
    logic            issue_stall;
    logic            md_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]     perf_stall_cyc;
    logic [31:0]     perf_single_cyc;
`endif

    issue_hazard_sched #(.MUL_LAT(MUL_LAT_TB), .DIV_LAT(DIV_LAT_TB)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ra1(in_ra1), .in_ra2(in_ra2),
        .in_rdst(in_rdst), .in_regwrite(in_regwrite), .in_late(in_late), .in_md_op(in_md_op),
        .in_hilo_rd(in_hilo_rd), .pipe_stall(pipe_stall), .flush(flush), .issue_en(issue_en),
        .issue_stall(issue_stall), .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cyc(perf_stall_cyc), .perf_single_cyc(perf_single_cyc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   expq[$];
    instr_t stream[$];
    prod_t  prods[$];
    int     free_at;
    int     n_pass;
    int     n_total;

    function automatic instr_t mk(input int a1, input int a2, input int d, input bit rw,
                                  input bit late, input int md, input bit hr);
        instr_t t;
        t.ra1 = 5'(a1); t.ra2 = 5'(a2); t.rdst = 5'(d);
        t.rw = rw; t.late = late; t.md = 2'(md); t.hr = hr;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        int k;
        k = int'($urandom_range(0, 99));
        if (k < 55)      return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'b1, 1'b0, 0, 1'b0);
        else if (k < 75) return mk($urandom_range(0, 7), 0, $urandom_range(0, 7), 1'b1, 1'b1, 0, 1'b0);
        else if (k < 80) return mk(0, 0, $urandom_range(1, 7), 1'b1, 1'b1, 0, 1'b1);
        else if (k < 85) return mk($urandom_range(0, 7), $urandom_range(0, 7), 0, 1'b0, 1'b0, 1, 1'b0);
        else if (k < 88) return mk($urandom_range(0, 7), $urandom_range(0, 7), 0, 1'b0, 1'b0, 2, 1'b0);
        else if (k < 90) return mk($urandom_range(0, 7), 0, 0, 1'b0, 1'b0, 3, 1'b0);
        else             return mk($urandom_range(0, 7), $urandom_range(0, 7), 0, 1'b0, 1'b0, 0, 1'b0);
    endfunction

    function automatic bit haz(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (prods[i]) if (prods[i].rdst == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int md_lat(input logic [1:0] md);
        case (md)
            2'b01:   return MUL_LAT_TB;
            2'b10:   return DIV_LAT_TB;
            default: return 1;
        endcase
    endfunction

    // Monitor: compare every presented cycle against the scoreboard entry.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e = expq.pop_front();
            act = {issue_en, issue_stall, md_busy};
            n_total++;
            if (act === e.val) n_pass++;
            else $display("FAIL sched cyc=%0d {issue_en,issue_stall,md_busy} actual=%b required=%b",
                          e.cyc, act, e.val);
        end
    end

    initial begin
        n_pass = 0; n_total = 0; free_at = 0;
        reset = 1'b1; in_valid = 2'b00; in_ra1 = '0; in_ra2 = '0; in_rdst = '0;
        in_regwrite = 2'b00; in_late = 2'b00; in_md_op = '0; in_hilo_rd = 2'b00;
        pipe_stall = 1'b0; flush = 1'b0;
        // Directed prefix: load-use, intra-pair dep, div->mflo, r0 producer/consumer.
        stream.push_back(mk(1, 0, 5, 1'b1, 1'b1, 0, 1'b0));
        stream.push_back(mk(5, 1, 6, 1'b1, 1'b0, 0, 1'b0));
        stream.push_back(mk(6, 2, 7, 1'b1, 1'b0, 0, 1'b0));
        stream.push_back(mk(1, 2, 0, 1'b0, 1'b0, 2, 1'b0));
        stream.push_back(mk(0, 0, 8, 1'b1, 1'b1, 0, 1'b1));
        stream.push_back(mk(1, 0, 0, 1'b1, 1'b1, 0, 1'b0));
        stream.push_back(mk(0, 3, 9, 1'b1, 1'b0, 0, 1'b0));

        for (int c = 0; c < NCYC; c++) begin
            bit rst_v, stall_v, flush_v, v0, v1, e0, e1, st, busy, quiet;
            instr_t i0, i1;
            exp_t ex;
            @(posedge clk);
            #1;
            while (stream.size() < 2) stream.push_back(rand_instr());
            quiet   = (c < QUIET);
            rst_v   = (c < 3) || (!quiet && ($urandom_range(0, 199) == 0));
            stall_v = !quiet && ($urandom_range(0, 99) < 12);
            flush_v = !quiet && ($urandom_range(0, 99) < 6);
            v0      = quiet ? 1'b1 : ($urandom_range(0, 99) < 90);
            v1      = v0 && (quiet ? 1'b1 : ($urandom_range(0, 99) < 80));
            i0 = stream[0];
            i1 = stream[1];

            reset = rst_v; pipe_stall = stall_v; flush = flush_v;
            in_valid = {v1, v0};
            in_ra1 = {i1.ra1, i0.ra1}; in_ra2 = {i1.ra2, i0.ra2}; in_rdst = {i1.rdst, i0.rdst};
            in_regwrite = {i1.rw, i0.rw}; in_late = {i1.late, i0.late};
            in_md_op = {i1.md, i0.md}; in_hilo_rd = {i1.hr, i0.hr};

            ex.cyc = c;
            if (rst_v) begin
                ex.val = 4'b0000;
                prods.delete();
                free_at = 0;
            end else begin
                busy = (c < free_at);
                e0 = v0 && !stall_v && !flush_v && !haz(i0.ra1) && !haz(i0.ra2) &&
                     (!(i0.hr || i0.md != 2'b00) || !busy);
                e1 = e0 && v1 && !haz(i1.ra1) && !haz(i1.ra2) &&
                     (!(i1.hr || i1.md != 2'b00) || !busy) &&
                     !(i0.rw && i0.rdst != 5'd0 && (i0.rdst == i1.ra1 || i0.rdst == i1.ra2)) &&
                     !(i0.md != 2'b00 && (i1.hr || i1.md != 2'b00)) &&
                     !(i0.late && i1.late);
                st = v0 && !e0 && !stall_v && !flush_v;
                ex.val = {e1, e0, st, busy};

                if (e0 && i0.md != 2'b00)      free_at = c + 1 + md_lat(i0.md);
                else if (e1 && i1.md != 2'b00) free_at = c + 1 + md_lat(i1.md);

                if (flush_v) begin
                    for (int k = prods.size() - 1; k >= 0; k--) if (prods[k].age == 0) prods.delete(k);
                end
                if (!stall_v) begin
                    for (int k = prods.size() - 1; k >= 0; k--) begin
                        prods[k].age++;
                        if (prods[k].age > 2) prods.delete(k);
                    end
                    if (e0 && i0.late && i0.rw) prods.push_back('{i0.rdst, 0});
                    if (e1 && i1.late && i1.rw) prods.push_back('{i1.rdst, 0});
                end

                if (flush_v) begin
                    if (v0) void'(stream.pop_front());
                    if (v1) void'(stream.pop_front());
                end else begin
                    if (e0) void'(stream.pop_front());
                    if (e1) void'(stream.pop_front());
                end
            end
            expq.push_back(ex);
        end

        @(posedge clk);
        #1;
        in_valid = 2'b00; pipe_stall = 1'b0; flush = 1'b0; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (expq.size() == 0) n_pass++;
        else $display("FAIL drain leftover_entries actual=%0d required=0", expq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
